// File: rtl/l2_dbg_port_arbiter.sv
// l2_dbg_port_arbiter: shares one L2 SRAM bank between JTAG debug (m0) and interconnect (m1).
// m1 wins by default; m0 is forced through after MAX_WAIT consecutive denied cycles.
module l2_dbg_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT = 8,
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    input  logic [BE_WIDTH-1:0]   m0_be_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    input  logic [BE_WIDTH-1:0]   m1_be_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  mem_csn_o,
    output logic                  mem_wen_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  perf_clr_i,
    output logic [15:0]           perf_conflicts_o
);
    logic [7:0]  r_wait;
    logic        r_rsp, r_owner, r_rd;
    logic [15:0] r_perf;
    logic        w_gnt0, w_gnt1, w_any, w_we;

    // grants are gated by reset so nothing reaches the SRAM while rst_n is low
    assign w_gnt0 = rst_n & m0_req_i & (~m1_req_i | (r_wait == 8'(MAX_WAIT)));
    assign w_gnt1 = rst_n & m1_req_i & ~w_gnt0;
    assign w_any  = w_gnt0 | w_gnt1;
    assign w_we   = w_gnt0 ? m0_we_i : m1_we_i;

    assign m0_gnt_o    = w_gnt0;
    assign m1_gnt_o    = w_gnt1;
    assign mem_csn_o   = ~w_any;
    assign mem_wen_o   = ~(w_any & w_we);
    assign mem_addr_o  = w_gnt0 ? m0_addr_i  : w_gnt1 ? m1_addr_i  : '0;
    assign mem_wdata_o = w_gnt0 ? m0_wdata_i : w_gnt1 ? m1_wdata_i : '0;
    assign mem_be_o    = w_gnt0 ? m0_be_i    : w_gnt1 ? m1_be_i    : '0;

    assign m0_rvalid_o = r_rsp & ~r_owner;
    assign m1_rvalid_o = r_rsp & r_owner;
    assign m0_rdata_o  = (m0_rvalid_o & r_rd) ? mem_rdata_i : '0;
    assign m1_rdata_o  = (m1_rvalid_o & r_rd) ? mem_rdata_i : '0;
    assign perf_conflicts_o = r_perf;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_wait  <= '0;
            r_rsp   <= 1'b0;
            r_owner <= 1'b0;
            r_rd    <= 1'b0;
            r_perf  <= '0;
        end else begin
            r_wait  <= (m0_req_i & ~w_gnt0) ? r_wait + 8'd1 : 8'd0;
            r_rsp   <= w_any;
            r_owner <= w_gnt1;
            r_rd    <= ~w_we;
            r_perf  <= perf_clr_i ? 16'd0 : (m0_req_i & m1_req_i & ~&r_perf) ? r_perf + 16'd1 : r_perf;
        end
    end
endmodule
